// File: rtl/inert_multi_intf.sv
// -----------------------------------------------------------------------------
// inert_multi_intf
// Inertial sensor reader. After power-up it waits a programmable interval,
// writes three configuration registers through an SPI master (SPI_mnrch), and
// then, each time the sensor raises INT, reads NUM_AXES 16-bit axes as
// low/high byte pairs. The bytes are collected in shadow registers and
// published to axis_data all at once, together with a one-cycle vld pulse.
//
// Parameters
//   NUM_AXES  : number of 16-bit axes read per INT (1..6)
//   BASE_ADDR : 7-bit register address of the low byte of axis 0
//   RST_W     : width of the power-up wait counter
//
// Ports
//   clk       in   system clock (the only clock)
//   rst_n     in   asynchronous active-low reset
//   INT       in   asynchronous sensor data-ready
//   done      in   SPI transaction-complete pulse
//   rd_data   in   SPI read data (only [7:0] is used)
//   clr_ovr   in   clears the sticky overrun flag
//   wrt       out  one-cycle pulse that starts an SPI transaction
//   cmd       out  SPI write data, valid while wrt=1, otherwise 16'h0000
//   axis_data out  published axes, axis k in bits [16k+15:16k]
//   vld       out  one-cycle pulse when a new axis_data set is published
//   ovr       out  sticky: INT rose while a read burst was in progress
//   err       out  sticky SPI timeout flag (only with INERT_TIMEOUT_EN)
//
// Build option
//   INERT_TIMEOUT_EN : adds a 12-bit watchdog on done and the err port.
//                      Without it the block waits for done indefinitely.
// -----------------------------------------------------------------------------
module inert_multi_intf #(
   parameter int         NUM_AXES  = 3,
   parameter logic [6:0] BASE_ADDR = 7'h22,
   parameter int         RST_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   INT,
   input  logic                   done,
   input  logic [15:0]            rd_data,
   input  logic                   clr_ovr,
   output logic                   wrt,
   output logic [15:0]            cmd,
   output logic [16*NUM_AXES-1:0] axis_data,
   output logic                   vld,
   output logic                   ovr
`ifdef INERT_TIMEOUT_EN
   ,
   output logic                   err
`endif
);

   typedef enum logic [2:0] {
      WAIT_RST  = 3'd0,
      INIT      = 3'd1,
      INIT_LAST = 3'd2,
      IDLE      = 3'd3,
      RD_LO     = 3'd4,
      RD_HI     = 3'd5,
      PUBLISH   = 3'd6
   } state_t;

   localparam logic [2:0] LAST_K = 3'(NUM_AXES - 1);

   // Read command: bit 15 set marks a read, address in [14:8].
   function automatic logic [15:0] read_cmd(input logic [6:0] addr);
      return {1'b1, addr, 8'h00};
   endfunction

   // Byte address of axis k: low byte at BASE_ADDR+2k, high byte one above.
   function automatic logic [6:0] axis_addr(input logic [2:0] k, input logic hi);
      return BASE_ADDR + {3'b000, k, hi};
   endfunction

   // ---------------------------------------------------------------------------
   // Registers and next-state signals
   // ---------------------------------------------------------------------------
   state_t                     state_r, state_s;
   logic [RST_W-1:0]           cnt_r, cnt_s;
   logic [1:0]                 init_idx_r, init_idx_s;
   logic [2:0]                 k_r, k_s;
   logic                       wrt_r, wrt_s;
   logic [15:0]                cmd_r, cmd_s;
   logic                       vld_r;
   logic                       ovr_r, ovr_s;
   logic                       cap_lo_s, cap_hi_s, pub_s;
   logic                       rise_s;
   logic                       timeout_s;

   logic                       int_meta_r, int_sync_r, int_prev_r;

   logic [NUM_AXES-1:0][7:0]   sh_lo_r, sh_hi_r;
   logic [16*NUM_AXES-1:0]     axis_r;

   // Only the low byte of each SPI response carries sensor data.
   logic                       unused_rd_hi;
   assign unused_rd_hi = ^rd_data[15:8];

   // Two-flop INT synchronizer (int_sync_r is INT_s) plus one delay for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_meta_r <= 1'b0;
         int_sync_r <= 1'b0;
         int_prev_r <= 1'b0;
      end else begin
         int_meta_r <= INT;
         int_sync_r <= int_meta_r;
         int_prev_r <= int_sync_r;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional done watchdog
   // ---------------------------------------------------------------------------
`ifdef INERT_TIMEOUT_EN
   logic [11:0] wd_r;
   logic        err_r;
   logic        wd_active_s;

   assign wd_active_s = (state_r == INIT) || (state_r == INIT_LAST) ||
                        (state_r == RD_LO) || (state_r == RD_HI);
   // Fire on the edge where the count would become FFF, so err appears
   // together with the watchdog reaching FFF. A done in that cycle wins.
   assign timeout_s   = wd_active_s && (wd_r == 12'hFFE) && !done;

   // Watchdog counter: restarts with every command, counts while a done is owed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_r  <= 12'h000;
         err_r <= 1'b0;
      end else begin
         if (wrt_s || !wd_active_s) begin
            wd_r <= 12'h000;
         end else begin
            wd_r <= wd_r + 12'h001;
         end
         err_r <= err_r | timeout_s;
      end
   end

   assign err = err_r;
`else
   assign timeout_s = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------

   // Next-state and command generation
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      init_idx_s = init_idx_r;
      k_s        = k_r;
      wrt_s      = 1'b0;
      cmd_s      = 16'h0000;
      cap_lo_s   = 1'b0;
      cap_hi_s   = 1'b0;
      pub_s      = 1'b0;

      if (timeout_s) begin
         // Counter preset to all-ones: the init write goes out next cycle.
         state_s = WAIT_RST;
         cnt_s   = {RST_W{1'b1}};
      end else begin
         case (state_r)
            WAIT_RST: begin
               if (cnt_r == {RST_W{1'b1}}) begin
                  wrt_s      = 1'b1;
                  cmd_s      = 16'h0D02;
                  init_idx_s = 2'd1;
                  state_s    = INIT;
               end else begin
                  cnt_s = cnt_r + RST_W'(1);
               end
            end

            INIT: begin
               if (done) begin
                  wrt_s      = 1'b1;
                  init_idx_s = init_idx_r + 2'd1;
                  if (init_idx_r == 2'd1) begin
                     cmd_s = 16'h1160;
                  end else begin
                     cmd_s   = 16'h1440;
                     state_s = INIT_LAST;
                  end
               end else begin
                  state_s = INIT;
               end
            end

            INIT_LAST: begin
               if (done) begin
                  state_s = IDLE;
               end else begin
                  state_s = INIT_LAST;
               end
            end

            IDLE: begin
               // Level-sensitive: INT still high on return starts a new burst.
               if (int_sync_r) begin
                  wrt_s   = 1'b1;
                  cmd_s   = read_cmd(axis_addr(3'd0, 1'b0));
                  k_s     = 3'd0;
                  state_s = RD_LO;
               end else begin
                  state_s = IDLE;
               end
            end

            RD_LO: begin
               if (done) begin
                  cap_lo_s = 1'b1;
                  wrt_s    = 1'b1;
                  cmd_s    = read_cmd(axis_addr(k_r, 1'b1));
                  state_s  = RD_HI;
               end else begin
                  state_s = RD_LO;
               end
            end

            RD_HI: begin
               if (done) begin
                  cap_hi_s = 1'b1;
                  if (k_r == LAST_K) begin
                     state_s = PUBLISH;
                  end else begin
                     k_s     = k_r + 3'd1;
                     wrt_s   = 1'b1;
                     cmd_s   = read_cmd(axis_addr(k_r + 3'd1, 1'b0));
                     state_s = RD_LO;
                  end
               end else begin
                  state_s = RD_HI;
               end
            end

            PUBLISH: begin
               pub_s   = 1'b1;
               state_s = IDLE;
            end

            default: begin
               state_s = WAIT_RST;
            end
         endcase
      end
   end

   // INT rising while a burst is still being collected means a sample was missed
   assign rise_s = int_sync_r && !int_prev_r &&
                   ((state_r == RD_LO) || (state_r == RD_HI) || (state_r == PUBLISH));

   // Sticky overrun: a set in the same cycle as a clear takes priority
   always_comb begin
      if (rise_s) begin
         ovr_s = 1'b1;
      end else if (clr_ovr) begin
         ovr_s = 1'b0;
      end else begin
         ovr_s = ovr_r;
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= WAIT_RST;
         cnt_r      <= {RST_W{1'b0}};
         init_idx_r <= 2'd0;
         k_r        <= 3'd0;
         wrt_r      <= 1'b0;
         cmd_r      <= 16'h0000;
         vld_r      <= 1'b0;
         ovr_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         init_idx_r <= init_idx_s;
         k_r        <= k_s;
         wrt_r      <= wrt_s;
         cmd_r      <= cmd_s;
         vld_r      <= pub_s;
         ovr_r      <= ovr_s;
      end
   end

   // Shadow byte capture and the single-cycle copy to the visible axis set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_lo_r <= {(8*NUM_AXES){1'b0}};
         sh_hi_r <= {(8*NUM_AXES){1'b0}};
         axis_r  <= {(16*NUM_AXES){1'b0}};
      end else begin
         for (int i = 0; i < NUM_AXES; i++) begin
            if (cap_lo_s && (k_r == 3'(i))) begin
               sh_lo_r[i] <= rd_data[7:0];
            end
            if (cap_hi_s && (k_r == 3'(i))) begin
               sh_hi_r[i] <= rd_data[7:0];
            end
            // axis_data changes only here, so a partial burst is never seen.
            if (pub_s) begin
               axis_r[16*i +: 16] <= {sh_hi_r[i], sh_lo_r[i]};
            end
         end
      end
   end

   assign wrt       = wrt_r;
   assign cmd       = cmd_r;
   assign vld       = vld_r;
   assign ovr       = ovr_r;
   assign axis_data = axis_r;

endmodule

// File: tb/tb_inert_multi_intf.sv
// -----------------------------------------------------------------------------
// tb_inert_multi_intf
// Self-checking bench for inert_multi_intf (NUM_AXES=3, BASE_ADDR=7'h22,
// RST_W=4). The bench plays the SPI master: it answers every wrt with a done
// after a random delay and random byte data, and keeps its own picture of the
// expected command order, the last published axis set and the overrun flag.
// -----------------------------------------------------------------------------
module tb_inert_multi_intf;

   localparam int         NA         = 3;
   localparam logic [6:0] BASE       = 7'h22;
   localparam int         RW         = 4;
   localparam int         RST_CYCLES = 1 << RW;
   localparam logic [15:0] FIXED_CMDS [6] = '{16'hA200, 16'hA300, 16'hA400,
                                             16'hA500, 16'hA600, 16'hA700};

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              INT     = 1'b0;
   logic              done    = 1'b0;
   logic [15:0]       rd_data = 16'h0000;
   logic              clr_ovr = 1'b0;
   logic              wrt;
   logic [15:0]       cmd;
   logic [16*NA-1:0]  axis_data;
   logic              vld;
   logic              ovr;
`ifdef INERT_TIMEOUT_EN
   logic              err;
`endif

   int                checks = 0;
   int                errors = 0;
   logic              ovr_exp;
   logic [16*NA-1:0]  data_exp;

   inert_multi_intf #(
      .NUM_AXES (NA),
      .BASE_ADDR(BASE),
      .RST_W    (RW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .INT      (INT),
      .done     (done),
      .rd_data  (rd_data),
      .clr_ovr  (clr_ovr),
      .wrt      (wrt),
      .cmd      (cmd),
      .axis_data(axis_data),
      .vld      (vld),
      .ovr      (ovr)
`ifdef INERT_TIMEOUT_EN
      ,
      .err      (err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Read r of a burst addresses BASE + r (lo/hi bytes interleave per axis).
   function automatic logic [15:0] exp_cmd(input int r);
      logic [6:0] a;
      a = BASE + 7'(r);
      return {1'b1, a, 8'h00};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle in which nothing should be issued or published.
   task automatic step(input string tag);
      tick();
      check_val({tag, "_wrt"},  wrt, 1'b0);
      check_val({tag, "_cmd"},  cmd, 16'h0000);
      check_val({tag, "_vld"},  vld, 1'b0);
      check_val({tag, "_axis"}, axis_data, data_exp);
   endtask

   // Answer an outstanding transaction; optionally raise INT meanwhile.
   task automatic spi_done(input logic [7:0] b, input int dly, input bit inj, input bit both);
      if (inj) begin
         INT = 1'b1;
         step("inj_a");
         step("inj_b");
         INT     = 1'b0;
         clr_ovr = both;
         step("inj_c");
         clr_ovr = 1'b0;
         if (both) check_val("ovr_set_wins", ovr, 1'b1);
      end
      repeat (dly) step("await_done");
      done    = 1'b1;
      rd_data = {8'($urandom), b};
      tick();
      done    = 1'b0;
      rd_data = 16'($urandom);
   endtask

   task automatic wait_first_wrt();
      int n;
      n = 0;
      do begin
         tick();
         n++;
         done = (n == 5);   // done must be ignored while waiting
      end while (wrt !== 1'b1 && n < 64);
      done = 1'b0;
      check_val("init_wait_cycles", n, RST_CYCLES);
      check_val("init_cmd0", cmd, 16'h0D02);
   endtask

   task automatic finish_init(input bit noise);
      spi_done(8'h00, $urandom_range(1, 3), noise, 1'b0);
      check_val("init_wrt1", wrt, 1'b1);
      check_val("init_cmd1", cmd, 16'h1160);
      spi_done(8'h00, $urandom_range(1, 3), 1'b0, 1'b0);
      check_val("init_wrt2", wrt, 1'b1);
      check_val("init_cmd2", cmd, 16'h1440);
      spi_done(8'h00, $urandom_range(1, 3), 1'b0, 1'b0);
      check_val("init_last_wrt", wrt, 1'b0);
      repeat (4) step("idle_after_init");
      check_val("init_ovr", ovr, ovr_exp);
   endtask

   task automatic start_burst();
      int n;
      INT = 1'b1;
      tick();
      tick();
      INT = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (wrt !== 1'b1 && n < 8);
      check_val("burst_start", wrt, 1'b1);
   endtask

   // Expects wrt for the first read visible now; runs the burst to vld.
   task automatic burst(input bit fixed, input bit held, input int inj, input bit both);
      logic [7:0] lo [NA];
      logic [7:0] hi [NA];
      int n;
      for (int k = 0; k < NA; k++) begin
         lo[k] = fixed ? 8'(17 + 34*k) : 8'($urandom);
         hi[k] = fixed ? 8'(34 + 34*k) : 8'($urandom);
      end
      for (int r = 0; r < 2*NA; r++) begin
         check_val("rd_wrt", wrt, 1'b1);
         check_val("rd_cmd", cmd, exp_cmd(r));
         if (fixed) check_val("fixed_cmd", cmd, FIXED_CMDS[r]);
         spi_done((r % 2) ? hi[r/2] : lo[r/2], $urandom_range(1, 4), inj == r, both);
         if (inj == r) ovr_exp = 1'b1;
      end
      check_val("publish_no_wrt", wrt, 1'b0);
      n = 0;
      do begin
         tick();
         n++;
      end while (vld !== 1'b1 && n < 4);
      check_val("vld_seen", vld, 1'b1);
      for (int k = 0; k < NA; k++) data_exp[16*k +: 16] = {hi[k], lo[k]};
      check_val("axis_pub", axis_data, data_exp);
      if (fixed) check_val("axis_fixed", axis_data, 48'h6655_4433_2211);
      tick();
      check_val("vld_single", vld, 1'b0);
      check_val("axis_hold", axis_data, data_exp);
      if (held) begin
         check_val("held_wrt", wrt, 1'b1);
         check_val("held_cmd", cmd, 16'hA200);
      end else begin
         check_val("after_pub_wrt", wrt, 1'b0);
      end
   endtask

   task automatic clear_ovr();
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      ovr_exp = 1'b0;
      check_val("ovr_cleared", ovr, 1'b0);
   endtask

   initial begin
      int n;
      int inj;
      bit both;
      ovr_exp  = 1'b0;
      data_exp = '0;

      // Reset state
      repeat (3) tick();
      check_val("rst_wrt", wrt, 1'b0);
      check_val("rst_cmd", cmd, 16'h0000);
      check_val("rst_vld", vld, 1'b0);
      check_val("rst_ovr", ovr, 1'b0);
      check_val("rst_axis", axis_data, data_exp);
`ifdef INERT_TIMEOUT_EN
      check_val("rst_err", err, 1'b0);
`endif

      // Power-up sequence, with an INT pulse during INIT that must be ignored
      rst_n = 1'b1;
      wait_first_wrt();
      finish_init(1'b1);

      // done in IDLE is ignored
      done = 1'b1;
      step("idle_done");
      done = 1'b0;
      repeat (3) step("idle_quiet");

      // Known byte pattern
      start_burst();
      burst(1'b1, 1'b0, -1, 1'b0);
      check_val("ovr_none", ovr, ovr_exp);

      // Second INT edge during the high-byte read of axis 1
      start_burst();
      burst(1'b0, 1'b0, 3, 1'b0);
      check_val("ovr_rd_hi", ovr, 1'b1);
      clear_ovr();

      // INT held high across PUBLISH restarts immediately
      INT = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (wrt !== 1'b1 && n < 8);
      check_val("held_start", wrt, 1'b1);
      burst(1'b0, 1'b1, -1, 1'b0);
      INT = 1'b0;
      burst(1'b0, 1'b0, -1, 1'b0);
      check_val("held_ovr", ovr, ovr_exp);

      // Randomized bursts with random overrun injection
      for (int b = 0; b < 10; b++) begin
         start_burst();
         inj  = $urandom_range(0, 9);
         both = 1'($urandom_range(0, 1));
         burst(1'b0, 1'b0, (inj < 2*NA) ? inj : -1, both);
         check_val("rand_ovr", ovr, ovr_exp);
         if (ovr_exp) clear_ovr();
      end

`ifdef INERT_TIMEOUT_EN
      // done withheld in RD_LO
      start_burst();
      n = 0;
      do begin
         tick();
         n++;
      end while (err !== 1'b1 && n < 5000);
      check_val("timeout_cycles", n, 4095);
      tick();
      check_val("timeout_rewrt", wrt, 1'b1);
      check_val("timeout_cmd", cmd, 16'h0D02);
      finish_init(1'b0);
      check_val("err_sticky", err, 1'b1);
`endif

      // Reset in RD_HI: everything clears at once and init reruns
      start_burst();
      check_val("mid_cmd0", cmd, exp_cmd(0));
      spi_done(8'h5A, 2, 1'b1, 1'b0);
      ovr_exp = 1'b1;
      check_val("mid_wrt1", wrt, 1'b1);
      check_val("mid_cmd1", cmd, exp_cmd(1));
      tick();
      rst_n = 1'b0;
      #1;
      check_val("arst_wrt", wrt, 1'b0);
      check_val("arst_cmd", cmd, 16'h0000);
      check_val("arst_vld", vld, 1'b0);
      check_val("arst_ovr", ovr, 1'b0);
      check_val("arst_axis", axis_data, {(16*NA){1'b0}});
`ifdef INERT_TIMEOUT_EN
      check_val("arst_err", err, 1'b0);
`endif
      ovr_exp  = 1'b0;
      data_exp = '0;
      tick();
      tick();
      rst_n = 1'b1;
      wait_first_wrt();
      finish_init(1'b0);
      start_burst();
      burst(1'b0, 1'b0, -1, 1'b0);
      check_val("recover_ovr", ovr, ovr_exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
